mux_rr_reg: RTL and testbench

//   N-input, W-bit registered multiplexer with valid/ready handshake on every channel.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mux_rr_reg.sv | 52 +++++
 tb/tb_mux_rr_reg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: arbitration mode constants, output-register state type and index-width helper
package mux_pkg;
  localparam int MUX_MODE_FIXED = 0;
  localparam int MUX_MODE_RR = 1;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant, lowest index or first request at/after ptr
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int MODE = MUX_MODE_RR,
  localparam int IDXW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);
  int start, j;
  // scan from the far end so the request closest to start is written last
  always_comb begin
    start = (MODE == MUX_MODE_RR) ? int'(ptr) : 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = start + k;
      j = (j >= N) ? j - N : j;
      if (req[j]) begin
        gnt_idx = IDXW'(j);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-way arbitrated mux into a one-entry valid/ready output register
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  parameter int MODE = MUX_MODE_RR,
  localparam int IDXW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [IDXW-1:0] out_sel,
  input  logic            out_ready
);
  state_t state, state_n;
  logic [IDXW-1:0] ptr, gnt_idx;
  logic gnt_any, load;
  rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
    .req(in_valid),
    .ptr(ptr),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );
  // rst_n gates load so in_ready is silent while reset is held
  assign load = rst_n & gnt_any & ((state == EMPTY) | out_ready);
  assign in_ready = load ? N'(1) << gnt_idx : '0;
  assign out_valid = state == FULL;
  always_comb begin
    state_n = state;
    state_n = load ? FULL : (out_ready ? EMPTY : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        out_data <= in_data[gnt_idx*W +: W];
        out_sel <= gnt_idx;
        if (MODE == MUX_MODE_RR) ptr <= (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed and random checks of three configurations against a queue-free behavioural model
module tb_mux_rr_reg;
  import mux_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] va, ra, vb, rb;
  logic [2:0] vc, rc;
  logic [31:0] da, db;
  logic [23:0] dc;
  logic ora, orb, orc, ova, ovb, ovc;
  logic [7:0] oda, odb, odc;
  logic [1:0] osa, osb, osc;
  int checks = 0, errors = 0;
  int nn[3] = '{4, 4, 3};
  int mm[3] = '{1, 0, 1};
  logic mv[3];
  logic [7:0] md[3];
  int ms[3], mp[3];
  logic [3:0] cv[3];
  logic [31:0] cd[3];
  logic cr[3];

  mux_rr_reg #(.W(8), .N(4), .MODE(1)) dut_a (.clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da),
    .in_ready(ra), .out_valid(ova), .out_data(oda), .out_sel(osa), .out_ready(ora));
  mux_rr_reg #(.W(8), .N(4), .MODE(0)) dut_b (.clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db),
    .in_ready(rb), .out_valid(ovb), .out_data(odb), .out_sel(osb), .out_ready(orb));
  mux_rr_reg #(.W(8), .N(3), .MODE(1)) dut_c (.clk(clk), .rst_n(rst_n), .in_valid(vc), .in_data(dc),
    .in_ready(rc), .out_valid(ovc), .out_data(odc), .out_sel(osc), .out_ready(orc));

  task automatic apply;
    va = cv[0]; da = cd[0]; ora = cr[0];
    vb = cv[1]; db = cd[1]; orb = cr[1];
    vc = cv[2][2:0]; dc = cd[2][23:0]; orc = cr[2];
  endtask

  function automatic int grant(int id, logic [3:0] v);
    int ch;
    for (int k = 0; k < nn[id]; k++) begin
      ch = (mm[id] == 1) ? (mp[id] + k) % nn[id] : k;
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int id);
    logic [3:0] r;
    int g;
    r = '0;
    g = grant(id, cv[id]);
    if (g >= 0 && (!mv[id] || cr[id])) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge;
    int g;
    for (int id = 0; id < 3; id++) begin
      g = grant(id, cv[id]);
      if (g >= 0 && (!mv[id] || cr[id])) begin
        mv[id] = 1'b1;
        md[id] = cd[id][g*8 +: 8];
        ms[id] = g;
        if (mm[id] == 1) mp[id] = (g + 1) % nn[id];
      end else if (cr[id]) mv[id] = 1'b0;
    end
  endtask

  task automatic model_reset;
    for (int id = 0; id < 3; id++) begin
      mv[id] = 1'b0; md[id] = '0; ms[id] = 0; mp[id] = 0;
      cv[id] = '0; cd[id] = '0; cr[id] = 1'b1;
    end
  endtask

  function automatic logic [3:0] got_rdy(int id);
    return (id == 0) ? ra : (id == 1) ? rb : {1'b0, rc};
  endfunction
  function automatic logic got_ov(int id);
    return (id == 0) ? ova : (id == 1) ? ovb : ovc;
  endfunction
  function automatic logic [7:0] got_od(int id);
    return (id == 0) ? oda : (id == 1) ? odb : odc;
  endfunction
  function automatic int got_os(int id);
    return (id == 0) ? int'(osa) : (id == 1) ? int'(osb) : int'(osc);
  endfunction

  task automatic step(input int id, input logic [3:0] v, input logic [31:0] d, input logic r,
                      output logic [3:0] got, output logic [3:0] exp);
    @(negedge clk);
    cv[id] = v; cd[id] = d; cr[id] = r;
    apply();
    #1;
    got = got_rdy(id);
    exp = exp_rdy(id);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] g, e;
    do_reset();
    #1;
    checks++;
    if (ova !== 1'b0 || oda !== 8'h00 || osa !== 2'd0) begin
      errors++; $display("FAIL reset_init got v=%b d=%h s=%0d exp v=0 d=00 s=0", ova, oda, osa);
    end
    step(0, 4'b0001, 32'h0000003C, 1'b0, g, e);
    checks++;
    if (ova !== 1'b1 || oda !== 8'h3C) begin
      errors++; $display("FAIL reset_fill got v=%b d=%h exp v=1 d=3c", ova, oda);
    end
    @(negedge clk);
    cv[0] = 4'hF; cd[0] = 32'h44332211; cr[0] = 1'b1;
    apply();
    #1;
    checks++;
    if (ra !== exp_rdy(0)) begin
      errors++; $display("FAIL reset_pre_ready got %b exp %b", ra, exp_rdy(0));
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ova !== 1'b0 || oda !== 8'h00 || osa !== 2'd0 || ra !== 4'b0000) begin
      errors++; $display("FAIL reset_async got v=%b d=%h s=%0d r=%b exp v=0 d=00 s=0 r=0000", ova, oda, osa, ra);
    end
    model_reset();
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 4'b0000, 32'h0, 1'b0, g, e);
    checks++;
    if (ova !== 1'b0) begin
      errors++; $display("FAIL reset_no_replay got v=%b exp 0", ova);
    end
  endtask

  task automatic test_single;
    logic [3:0] g, e;
    do_reset();
    step(0, 4'b0100, 32'h00AA0000, 1'b1, g, e);
    checks++;
    if (g !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b exp 0100", g);
    end
    checks++;
    if (ova !== 1'b1 || oda !== 8'hAA || osa !== 2'd2) begin
      errors++; $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=aa s=2", ova, oda, osa);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] g, e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 4'hF, 32'h13121110, 1'b1, g, e);
      checks++;
      if (int'(osa) !== i % 4 || oda !== 8'(8'h10 + i % 4) || g !== e) begin
        errors++; $display("FAIL rr_seq[%0d] got s=%0d d=%h r=%b exp s=%0d d=%h r=%b", i, osa, oda, g, i % 4, 8'(8'h10 + i % 4), e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] g, e;
    do_reset();
    step(0, 4'b0001, 32'h00000053, 1'b1, g, e);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0010, 32'h00007700, 1'b0, g, e);
      checks++;
      if (g !== 4'b0000 || ova !== 1'b1 || oda !== 8'h53 || osa !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d] got r=%b v=%b d=%h s=%0d exp r=0000 v=1 d=53 s=0", i, g, ova, oda, osa);
      end
    end
    step(0, 4'b0010, 32'h00007700, 1'b1, g, e);
    checks++;
    if (g !== 4'b0010 || oda !== 8'h77 || osa !== 2'd1) begin
      errors++; $display("FAIL bp_release got r=%b d=%h s=%0d exp r=0010 d=77 s=1", g, oda, osa);
    end
    step(0, 4'b0000, 32'h0, 1'b1, g, e);
    checks++;
    if (ova !== 1'b0 || oda !== 8'h77 || osa !== 2'd1) begin
      errors++; $display("FAIL drain_hold got v=%b d=%h s=%0d exp v=0 d=77 s=1", ova, oda, osa);
    end
  endtask

  task automatic test_fixed;
    logic [3:0] g, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 4'b1010, 32'hD3C2B1A0, 1'b1, g, e);
      checks++;
      if (osb !== 2'd1 || odb !== 8'hB1 || g !== 4'b0010) begin
        errors++; $display("FAIL fixed_pri[%0d] got s=%0d d=%h r=%b exp s=1 d=b1 r=0010", i, osb, odb, g);
      end
    end
    step(1, 4'b1000, 32'hD3C2B1A0, 1'b1, g, e);
    checks++;
    if (osb !== 2'd3 || odb !== 8'hD3) begin
      errors++; $display("FAIL fixed_drop got s=%0d d=%h exp s=3 d=d3", osb, odb);
    end
  endtask

  task automatic test_npot;
    logic [3:0] g, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2, 4'b0111, 32'h00222120, 1'b1, g, e);
      checks++;
      if (int'(osc) !== i % 3 || odc !== 8'(8'h20 + i % 3) || dut_c.ptr === 2'd3) begin
        errors++; $display("FAIL npot_seq[%0d] got s=%0d d=%h ptr=%0d exp s=%0d d=%h ptr<3", i, osc, odc, dut_c.ptr, i % 3, 8'(8'h20 + i % 3));
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] g, e;
    int id;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      id = $urandom_range(0, 2);
      step(id, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0, g, e);
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL rand_ready[%0d] dut%0d got %b exp %b", n, id, g, e);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_ov(k) !== mv[k] || got_od(k) !== md[k] || got_os(k) !== ms[k]) begin
          errors++; $display("FAIL rand_out[%0d] dut%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", n, k, got_ov(k), got_od(k), got_os(k), mv[k], md[k], ms[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    apply();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fixed();
    test_npot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
